// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C request arbiter.
//   arb_state_t : arbiter FSM states
//   rsp_err_t   : completion status returned to the owning requester
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } rsp_err_t;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Bundle of requester-side and master-side signals of the I2C request arbiter.
//   slave  : arbiter view (consumes requests and master status, drives grants/responses/master controls)
//   master : environment view (requesters plus the I2C byte engine)
interface i2c_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import i2c_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*I2C_DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_rw;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [I2C_DATA_W-1:0]         rsp_rdata;
  rsp_err_t                      rsp_err;
  logic                          m_start;
  logic [I2C_ADDR_W-1:0]         m_addr;
  logic [I2C_DATA_W-1:0]         m_wdata;
  logic                          m_rw;
  logic                          m_busy;
  logic                          m_done;
  logic                          m_nack;
  logic [I2C_DATA_W-1:0]         m_rdata;
  logic [IDX_W-1:0]              owner;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_rw, m_busy, m_done, m_nack, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, m_start, m_addr, m_wdata, m_rw, owner
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_rw, m_busy, m_done, m_nack, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, m_start, m_addr, m_wdata, m_rw, owner
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
//   req : request vector       ptr : highest-priority index     en  : allow a grant
//   gnt : one-hot grant        idx : encoded grant index (0 when no grant)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + 32'(i)) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C byte-transaction master between NUM_REQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester valid/ready + packed addr/wdata/rw, per-requester
//                response pulse with rdata/err, master start/addr/wdata/rw,
//                master busy/done/nack/rdata, owner status
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  i2c_req_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d, owner_q, owner_d, gnt_idx;
  logic [NUM_REQ-1:0]    gnt, rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  m_start_q, m_start_d, m_rw_q, m_rw_d;
  logic [I2C_ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [I2C_DATA_W-1:0] m_wdata_q, m_wdata_d, rsp_rdata_q, rsp_rdata_d;
  rsp_err_t              rsp_err_q, rsp_err_d;
  logic                  active_q, arb_en, timeout;

  // active_q is low while rst_n is asserted, keeping req_ready at its reset value.
  assign arb_en = active_q && (state_q == ST_IDLE) && !bus.m_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // cnt_inc counts cycles since m_start; the abort is decided so that the
  // timeout response lands exactly TIMEOUT_CYC cycles after m_start.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign timeout = (cnt_inc == CNT_W'(TIMEOUT_CYC - 1));

  // Next-state and register updates.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    m_start_d   = 1'b0;
    rsp_valid_d = '0;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_rw_d      = m_rw_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          m_addr_d  = bus.req_addr[32'(gnt_idx) * I2C_ADDR_W +: I2C_ADDR_W];
          m_wdata_d = bus.req_wdata[32'(gnt_idx) * I2C_DATA_W +: I2C_DATA_W];
          m_rw_d    = bus.req_rw[gnt_idx];
          owner_d   = gnt_idx;
          ptr_d     = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          m_start_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // m_done takes priority over a coincident timeout.
        if (bus.m_done) begin
          rsp_rdata_d          = m_rw_q ? bus.m_rdata : '0;
          rsp_err_d            = bus.m_nack ? ERR_NACK : ERR_OK;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = ST_RESP;
        end else if (timeout) begin
          rsp_rdata_d          = '0;
          rsp_err_d            = ERR_TIMEOUT;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture, pointer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      m_start_q   <= 1'b0;
      rsp_valid_q <= '0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_rw_q      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      active_q    <= 1'b1;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      m_start_q   <= m_start_d;
      rsp_valid_q <= rsp_valid_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_rw_q      <= m_rw_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.m_start   = m_start_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_rw      = m_rw_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter (NUM_REQ=4, TIMEOUT_CYC=50).
module tb_i2c_req_arbiter;
  import i2c_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 50;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_req_arbiter_if #(.NUM_REQ(NR)) bus ();

  i2c_req_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         r;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    int         dly;      // cycles from m_start to m_done
    logic       nack;
    logic [7:0] mrd;      // byte returned by the master model
    logic [1:0] exp_err;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vec [5];
  vec_t v;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n;
  int   viol;
  int   expg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial begin
    vec[0] = '{1, 1'b0, 7'h48, 8'hA5, 20, 1'b0, 8'h77, 2'b00, 8'h00}; // single write
    vec[1] = '{2, 1'b1, 7'h1D, 8'h00,  5, 1'b0, 8'h3C, 2'b00, 8'h3C}; // read with data
    vec[2] = '{0, 1'b0, 7'h50, 8'h11,  3, 1'b1, 8'h00, 2'b01, 8'h00}; // NACK
    vec[3] = '{3, 1'b1, 7'h22, 8'h00,  1, 1'b0, 8'hC3, 2'b00, 8'hC3}; // fastest master
    vec[4] = '{1, 1'b1, 7'h7F, 8'h00, 49, 1'b0, 8'h5A, 2'b00, 8'h5A}; // done coincides with timeout

    rst_n = 1'b1;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_rw = '0;
    bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_nack = 1'b0; bus.m_rdata = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_m_start", bus.m_start, 0);
    chk("rst_m_fields", {bus.m_addr, bus.m_wdata, bus.m_rw}, 0);
    chk("rst_rsp", {bus.rsp_rdata, bus.rsp_err}, 0);
    chk("rst_owner", bus.owner, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single transactions.
    for (int i = 0; i < 5; i++) begin
      v = vec[i];
      @(negedge clk);
      bus.req_rw[v.r] = v.rw;
      bus.req_addr[v.r*7 +: 7] = v.addr;
      bus.req_wdata[v.r*8 +: 8] = v.wdata;
      bus.req_valid[v.r] = 1'b1;
      #1 chk($sformatf("v%0d_accept", i), bus.req_ready, 64'(4'b0001 << v.r));
      @(negedge clk);
      bus.req_valid[v.r] = 1'b0;
      #1 chk($sformatf("v%0d_m_start", i), bus.m_start, 1);
      chk($sformatf("v%0d_m_fields", i), {bus.m_rw, bus.m_addr, bus.m_wdata}, {v.rw, v.addr, v.wdata});
      chk($sformatf("v%0d_owner", i), bus.owner, v.r);
      @(negedge clk);
      #1 chk($sformatf("v%0d_start_pulse", i), {bus.m_start, bus.req_ready}, 0);
      repeat (v.dly - 1) @(negedge clk);
      bus.m_done = 1'b1; bus.m_nack = v.nack; bus.m_rdata = v.mrd;
      @(negedge clk);
      bus.m_done = 1'b0; bus.m_nack = 1'b0; bus.m_rdata = 8'h00;
      #1 chk($sformatf("v%0d_rsp_valid", i), bus.rsp_valid, 64'(4'b0001 << v.r));
      chk($sformatf("v%0d_rsp", i), {bus.rsp_err, bus.rsp_rdata}, {v.exp_err, v.exp_rd});
      @(negedge clk);
      #1 chk($sformatf("v%0d_rsp_pulse", i), bus.rsp_valid, 0);
    end

    // Timeout: master never completes. Pointer is 2 after the last grant (1).
    @(negedge clk);
    bus.req_rw[2] = 1'b1; bus.req_addr[14 +: 7] = 7'h33; bus.req_valid[2] = 1'b1;
    #1 chk("to_accept", bus.req_ready, 4'b0100);
    @(negedge clk);
    bus.req_valid[2] = 1'b0; bus.m_rdata = 8'hEE;
    #1 chk("to_m_start", bus.m_start, 1);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (bus.rsp_valid == '0 && n < 60);
    chk("to_latency", n, TO);
    chk("to_rsp_valid", bus.rsp_valid, 4'b0100);
    chk("to_rsp", {bus.rsp_err, bus.rsp_rdata}, {2'b10, 8'h00});
    @(negedge clk);
    bus.m_done = 1'b1; bus.m_nack = 1'b1;
    @(negedge clk);
    bus.m_done = 1'b0; bus.m_nack = 1'b0; bus.m_rdata = 8'h00;
    #1 chk("late_done_ignored", {bus.rsp_valid, bus.rsp_err, bus.m_start}, {4'b0000, 2'b10, 1'b0});

    // Pointer moved past the timed-out owner: 3 beats 2.
    bus.req_addr[21 +: 7] = 7'h44; bus.req_rw[3] = 1'b0;
    bus.req_valid[2] = 1'b1; bus.req_valid[3] = 1'b1;
    #1 chk("ptr_after_timeout", bus.req_ready, 4'b1000);
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    #1 chk("ptr_owner", {bus.m_start, bus.owner, bus.m_addr}, {1'b1, 2'd3, 7'h44});
    chk("busy_no_ready_issue", bus.req_ready, 0);
    @(negedge clk);
    bus.m_done = 1'b1;
    #1 chk("busy_no_ready_wait", bus.req_ready, 0);
    @(negedge clk);
    bus.m_done = 1'b0;
    #1 chk("ptr_rsp", {bus.rsp_valid, bus.req_ready}, {4'b1000, 4'b0000});
    @(negedge clk);
    bus.m_busy = 1'b1;
    #1 chk("m_busy_blocks", bus.req_ready, 0);
    @(negedge clk);
    #1 chk("m_busy_stays_idle", {bus.req_ready, bus.m_start}, 0);
    bus.m_busy = 1'b0;
    #1 chk("m_busy_release", bus.req_ready, 4'b0100);
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    #1 chk("dropped_req", bus.m_start, 0);

    // Reset in the middle of WAIT (pointer is 0 now, becomes 1 after this grant).
    bus.req_addr[0 +: 7] = 7'h2A; bus.req_wdata[0 +: 8] = 8'h99; bus.req_rw[0] = 1'b0;
    bus.req_valid[0] = 1'b1;
    #1 chk("rw_accept", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    #1 chk("rw_m_start", bus.m_start, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0; bus.req_valid[1] = 1'b1;
    #1 chk("rw_outputs_cleared",
           {bus.req_ready, bus.rsp_valid, bus.m_start, bus.m_addr, bus.m_wdata, bus.m_rw,
            bus.rsp_rdata, bus.rsp_err, bus.owner}, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 chk("rw_quiet_in_reset", {bus.rsp_valid, bus.req_ready}, 0);
    end
    bus.req_valid[1] = 1'b0;
    rst_n = 1'b1;

    // Fairness from pointer 0 with all requesters held.
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*7 +: 7] = 7'(8'h10 + i);
      bus.req_wdata[i*8 +: 8] = 8'(8'hF0 + i);
    end
    bus.req_rw = '0;
    bus.req_valid = '1;
    viol = 0;
    for (int k = 0; k < 8; k++) begin
      expg = k % 4;
      n = 0;
      do begin
        @(negedge clk); #1;
        if ($countones(bus.req_ready) > 1) viol++;
        if (bus.rsp_valid != '0) viol++;
        n++;
      end while (bus.req_ready == '0 && n < 10);
      chk($sformatf("fair_grant%0d", k), bus.req_ready, 64'(4'b0001 << expg));
      @(negedge clk);
      #1 chk($sformatf("fair_m_addr%0d", k), bus.m_addr, 7'(8'h10 + expg));
      if (bus.req_ready != '0) viol++;
      @(negedge clk);
      bus.m_done = 1'b1;
      #1 if (bus.req_ready != '0) viol++;
      @(negedge clk);
      bus.m_done = 1'b0;
      #1 chk($sformatf("fair_rsp%0d", k), bus.rsp_valid, 64'(4'b0001 << expg));
      if (bus.req_ready != '0) viol++;
    end
    chk("fair_onehot_and_quiet", viol, 0);
    bus.req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
